// File: rtl/irrigation_zone_sequencer_if.sv
// Control/status bundle for the irrigation zone sequencer.
// master drives the requests and presets; slave is the sequencer itself.
interface irrigation_zone_sequencer_if #(
    parameter int ZONES = 4
);
    localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;

    logic             start_request;
    logic             forced_reset_from_button;
    logic             irrigation_on;
    logic             conflicting_values;
    logic             splinker_mode_on;
    logic [ZW-1:0]    zone_select;
    logic [3:0]       preset_minutes_d;
    logic [3:0]       preset_minutes_u;
    logic [2:0]       preset_seconds_d;
    logic [3:0]       preset_seconds_u;

    logic [ZONES-1:0] valve_on;
    logic [ZW-1:0]    active_zone;
    logic [3:0]       minutes_d;
    logic [3:0]       minutes_u;
    logic [2:0]       seconds_d;
    logic [3:0]       seconds_u;
    logic             busy;
    logic             cycle_done;
    logic             timer_reset;

    modport master (
        output start_request, forced_reset_from_button, irrigation_on,
               conflicting_values, splinker_mode_on, zone_select,
               preset_minutes_d, preset_minutes_u, preset_seconds_d, preset_seconds_u,
        input  valve_on, active_zone, minutes_d, minutes_u, seconds_d, seconds_u,
               busy, cycle_done, timer_reset
    );

    modport slave (
        input  start_request, forced_reset_from_button, irrigation_on,
               conflicting_values, splinker_mode_on, zone_select,
               preset_minutes_d, preset_minutes_u, preset_seconds_d, preset_seconds_u,
        output valve_on, active_zone, minutes_d, minutes_u, seconds_d, seconds_u,
               busy, cycle_done, timer_reset
    );
endinterface

// File: rtl/irrigation_zone_sequencer.sv
// Irrigation zone sequencer: runs one zone, or all zones in turn, for a BCD
// MM:SS preset each, with immediate abort on operator/sensor inhibit.
module irrigation_zone_sequencer #(
    parameter int ZONES             = 4,
    parameter int CLOCKS_PER_SECOND = 1000
) (
    input logic                     clock,
    input logic                     reset_n,
    irrigation_zone_sequencer_if.slave bus
);
    localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int PW = (CLOCKS_PER_SECOND > 1) ? $clog2(CLOCKS_PER_SECOND) : 1;
    localparam logic [PW-1:0] PS_LAST   = PW'(CLOCKS_PER_SECOND - 1);
    localparam logic [PW-1:0] PS_ONE    = PW'(1);
    localparam logic [ZW-1:0] ZONE_LAST = ZW'(ZONES - 1);
    localparam logic [ZW-1:0] ZONE_ONE  = ZW'(1);

    typedef enum logic [1:0] {IDLE, RUN, NEXT, DONE} state_t;

    state_t        state, state_nx;
    logic [1:0]    rst_pipe;
    logic          rst_ok;
    logic [PW-1:0] presc;
    logic [3:0]    md, mu, su;
    logic [2:0]    sd;
    logic [3:0]    nmd, nmu, nsu;
    logic [2:0]    nsd;
    logic [3:0]    pmd, pmu, psu;
    logic [2:0]    psd;
    logic [ZW-1:0] zone, zone_sel_sat;
    logic          seq_mode;
    logic          abort, tick, cnt_zero, nxt_zero, zone_end, start_ok, preset_nz;

    // Reset release is retimed so the FSM never sees a half-released reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_ok = rst_pipe[1];

    assign pmd = bus.preset_minutes_d;
    assign pmu = (bus.preset_minutes_u > 4'd9) ? 4'd9 : bus.preset_minutes_u;
    assign psd = (bus.preset_seconds_d > 3'd5) ? 3'd5 : bus.preset_seconds_d;
    assign psu = (bus.preset_seconds_u > 4'd9) ? 4'd9 : bus.preset_seconds_u;
    assign preset_nz    = |{pmd, pmu, psd, psu};
    assign zone_sel_sat = (bus.zone_select > ZONE_LAST) ? ZONE_LAST : bus.zone_select;

    assign abort    = bus.forced_reset_from_button | ~bus.irrigation_on | bus.conflicting_values;
    assign tick     = (state == RUN) && (presc == PS_LAST);
    assign cnt_zero = ({md, mu, sd, su} == 15'd0);
    assign nxt_zero = ({nmd, nmu, nsd, nsu} == 15'd0);
    // A zero counter still ends the zone, so a zero reload can never stall RUN.
    assign zone_end = tick && (cnt_zero || nxt_zero);
    assign start_ok = rst_ok && bus.start_request && !abort && preset_nz;

    // One-second BCD decrement with borrow chain; only applied when nonzero.
    always_comb begin
        nsu = su - 4'd1;
        nsd = sd;
        nmu = mu;
        nmd = md;
        if (su == 4'd0) begin
            nsu = 4'd9;
            nsd = sd - 3'd1;
            if (sd == 3'd0) begin
                nsd = 3'd5;
                nmu = mu - 4'd1;
                if (mu == 4'd0) begin
                    nmu = 4'd9;
                    nmd = md - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_ok) state_nx = RUN;
            RUN:  if (zone_end) state_nx = (seq_mode && zone < ZONE_LAST) ? NEXT : DONE;
            NEXT: state_nx = RUN;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort || !rst_ok) state_nx = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= '0;
            md       <= '0;
            mu       <= '0;
            sd       <= '0;
            su       <= '0;
            zone     <= '0;
            seq_mode <= 1'b0;
        end else if (state != RUN && state_nx == RUN) begin
            presc <= '0;
            md    <= pmd;
            mu    <= pmu;
            sd    <= psd;
            su    <= psu;
            if (state == IDLE) begin
                seq_mode <= bus.splinker_mode_on;
                zone     <= bus.splinker_mode_on ? '0 : zone_sel_sat;
            end else begin
                zone <= zone + ZONE_ONE;
            end
        end else if (state == RUN && state_nx != IDLE) begin
            presc <= tick ? '0 : presc + PS_ONE;
            if (tick && !cnt_zero) begin
                md <= nmd;
                mu <= nmu;
                sd <= nsd;
                su <= nsu;
            end
        end
    end

    always_comb begin
        bus.valve_on = '0;
        for (int i = 0; i < ZONES; i++)
            bus.valve_on[i] = (state == RUN) && (zone == ZW'(i));
    end

    assign bus.active_zone = zone;
    assign bus.minutes_d   = md;
    assign bus.minutes_u   = mu;
    assign bus.seconds_d   = sd;
    assign bus.seconds_u   = su;
    assign bus.busy        = (state == RUN) || (state == NEXT);
    assign bus.cycle_done  = (state == DONE);
    assign bus.timer_reset = (state != RUN);
endmodule
